// File: rtl/pkt_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module  : pkt_ctrl_pkg
// Purpose : Shared state encoding and default sizing for the queued packet controller.
// Rev     : 1.0 - initial release
//==============================================================================
package pkt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RD_DONE = 2'd2,
    WR_DONE = 2'd3
  } pkt_state_e;

  localparam int DEF_LEN_W   = 16;
  localparam int DEF_QDEPTH  = 4;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_CNT_W   = 32;

endpackage
`default_nettype wire

// File: rtl/pkt_ctrl_q_if.sv
`default_nettype none
//==============================================================================
// Module  : pkt_ctrl_q_if
// Purpose : Request, engine handshake and status bundle of the queued packet controller.
// Rev     : 1.0 - initial release
//==============================================================================
interface pkt_ctrl_q_if import pkt_ctrl_pkg::*; #(
  parameter int LEN_W  = DEF_LEN_W,
  parameter int QDEPTH = DEF_QDEPTH,
  parameter int CNT_W  = DEF_CNT_W
);
  logic                      req_valid;
  logic [LEN_W-1:0]          req_len;
  logic                      req_ready;
  logic                      rd_start;
  logic                      wr_start;
  logic [LEN_W-1:0]          xfer_len;
  logic                      rd_ctrl_rdy;
  logic                      wr_ctrl_rdy;
  logic                      abort;
  logic                      err_clr;
  logic [1:0]                state_out;
  logic                      busy;
  logic                      done;
  logic                      timeout_err;
  logic [CNT_W-1:0]          pkt_count;
  logic [$clog2(QDEPTH):0]   q_level;

  modport master (
    output req_valid, req_len, rd_ctrl_rdy, wr_ctrl_rdy, abort, err_clr,
    input  req_ready, rd_start, wr_start, xfer_len, state_out, busy, done,
           timeout_err, pkt_count, q_level
  );

  modport slave (
    input  req_valid, req_len, rd_ctrl_rdy, wr_ctrl_rdy, abort, err_clr,
    output req_ready, rd_start, wr_start, xfer_len, state_out, busy, done,
           timeout_err, pkt_count, q_level
  );

endinterface
`default_nettype wire

// File: rtl/pkt_req_fifo.sv
`default_nettype none
//==============================================================================
// Module  : pkt_req_fifo
// Purpose : Show-ahead synchronous FIFO holding pending transfer lengths.
// Rev     : 1.0 - initial release
//==============================================================================
module pkt_req_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire                     clk,
  input  wire                     reset,
  input  wire                     push,
  input  wire  [WIDTH-1:0]        push_data,
  input  wire                     pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  // Accept/remove only when legal, so a full-queue push never lands even alongside a pop.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_level == (PTR_W+1)'(DEPTH));
  assign empty    = (r_level == '0);
  assign level    = r_level;

endmodule
`default_nettype wire

// File: rtl/pkt_ctrl_q.sv
`default_nettype none
//==============================================================================
// Module  : pkt_ctrl_q
// Purpose : Queued packet-transfer controller: dispatch, rd/wr completion, watchdog, abort.
// Rev     : 1.0 - initial release
//==============================================================================
module pkt_ctrl_q import pkt_ctrl_pkg::*; #(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int QDEPTH  = DEF_QDEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  wire          clk,
  input  wire          reset,
  pkt_ctrl_q_if.slave  bus
);
  localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] C_WD_MAX = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              C_WD_EN  = (TIMEOUT > 0);

  pkt_state_e              r_state;
  pkt_state_e              w_next;
  logic [LEN_W-1:0]        w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(QDEPTH):0] w_level;
  logic                    w_pop;
  logic                    w_dispatch;
  logic                    w_timeout;
  logic                    w_complete;
  logic                    w_wd_hit;
  logic                    r_start;
  logic [LEN_W-1:0]        r_xfer_len;
  logic [WD_W-1:0]         r_wdog;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;

  pkt_req_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.req_valid),
    .push_data (bus.req_len),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // In flight, abort outranks the watchdog, which outranks engine completion.
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_dispatch = 1'b0;
    w_timeout  = 1'b0;
    w_complete = 1'b0;
    w_wd_hit   = C_WD_EN && (r_wdog == C_WD_MAX);
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head != '0) begin
            w_dispatch = 1'b1;
            w_next     = RUN;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end else if (bus.rd_ctrl_rdy) begin
          w_next = bus.wr_ctrl_rdy ? WR_DONE : RD_DONE;
        end
      end
      RD_DONE: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end else if (bus.wr_ctrl_rdy) begin
          w_next = WR_DONE;
        end
      end
      WR_DONE: begin
        w_complete = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start    <= 1'b0;
      r_xfer_len <= '0;
      r_wdog     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_start <= w_dispatch;
      if (w_dispatch) begin
        r_xfer_len <= w_head;
        r_wdog     <= '0;
      end else if (r_state == RUN || r_state == RD_DONE) begin
        r_wdog <= r_wdog + WD_W'(1);
      end
      if (w_complete) r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout)        r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;
    end
  end

  assign bus.req_ready   = !w_full;
  assign bus.rd_start    = r_start;
  assign bus.wr_start    = r_start;
  assign bus.xfer_len    = r_xfer_len;
  assign bus.state_out   = r_state;
  assign bus.busy        = (r_state == RUN) || (r_state == RD_DONE);
  assign bus.done        = (r_state == WR_DONE) || ((r_state == IDLE) && w_empty);
  assign bus.timeout_err = r_err;
  assign bus.pkt_count   = r_cnt;
  assign bus.q_level     = w_level;

endmodule
`default_nettype wire

// File: tb/tb_pkt_ctrl_q.sv
`default_nettype none
//==============================================================================
// Module  : tb_pkt_ctrl_q
// Purpose : Directed self-checking bench for pkt_ctrl_q (QDEPTH=4, TIMEOUT=16).
// Rev     : 1.0 - initial release
//==============================================================================
module tb_pkt_ctrl_q;
  localparam int NV = 25;

  typedef struct {
    int v, len, rd, wr, ab, clr;
    int st, start, xl, ql, cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks  = 0;
  int   fails   = 0;
  int   exp_cnt = 0;
  vec_t tbl [NV];

  pkt_ctrl_q_if #(.LEN_W(16), .QDEPTH(4), .CNT_W(32)) bus ();

  pkt_ctrl_q #(
    .LEN_W   (16),
    .QDEPTH  (4),
    .TIMEOUT (16),
    .CNT_W   (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; a request presented while ready is dropped once it has been taken.
  task automatic step();
    logic acc;
    acc = bus.req_valid && bus.req_ready;
    @(posedge clk);
    #1;
    if (acc) bus.req_valid = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int st, input int ql);
    chk({tag, "_state"}, int'(bus.state_out), st);
    chk({tag, "_qlvl"},  int'(bus.q_level), ql);
    chk({tag, "_ready"}, int'(bus.req_ready), (ql < 4) ? 1 : 0);
    chk({tag, "_busy"},  int'(bus.busy), (st == 1 || st == 2) ? 1 : 0);
    chk({tag, "_done"},  int'(bus.done), (st == 3 || (st == 0 && ql == 0)) ? 1 : 0);
  endtask

  task automatic wait_start(input int len);
    int n = 0;
    while (bus.rd_start !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("start_seen", int'(bus.rd_start), 1);
    chk("wr_start_with_rd", int'(bus.wr_start), 1);
    chk("xfer_len", int'(bus.xfer_len), len);
    chk("start_state", int'(bus.state_out), 1);
  endtask

  task automatic finish_pkt();
    bus.rd_ctrl_rdy = 1'b1;
    step();
    bus.rd_ctrl_rdy = 1'b0;
    chk("fin_rd_done", int'(bus.state_out), 2);
    bus.wr_ctrl_rdy = 1'b1;
    step();
    bus.wr_ctrl_rdy = 1'b0;
    chk("fin_wr_done", int'(bus.state_out), 3);
    chk("fin_done_flag", int'(bus.done), 1);
    step();
    exp_cnt++;
    chk("fin_idle", int'(bus.state_out), 0);
    chk("fin_count", int'(bus.pkt_count), exp_cnt);
  endtask

  task automatic run_to_timeout(input string tag);
    int n = 0;
    while (bus.state_out == 2'd1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_cycles"}, n, 16);
    chk({tag, "_err"},    int'(bus.timeout_err), 1);
    chk({tag, "_state"},  int'(bus.state_out), 0);
    chk({tag, "_count"},  int'(bus.pkt_count), exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench stopped by time limit");
  end

  initial begin
    string tag;
    bus.req_valid   = 1'b0;
    bus.req_len     = '0;
    bus.rd_ctrl_rdy = 1'b0;
    bus.wr_ctrl_rdy = 1'b0;
    bus.abort       = 1'b0;
    bus.err_clr     = 1'b0;
    reset           = 1'b1;
    step();
    step();
    chk_status("reset", 0, 0);
    chk("reset_rd_start", int'(bus.rd_start), 0);
    chk("reset_wr_start", int'(bus.wr_start), 0);
    chk("reset_xfer_len", int'(bus.xfer_len), 0);
    chk("reset_count", int'(bus.pkt_count), 0);
    chk("reset_err", int'(bus.timeout_err), 0);
    reset = 1'b0;

    //           v  len rd wr ab clr  st start xl ql cnt
    tbl[0]  = '{1,  64, 0, 0, 0, 0,   0, 0,    0, 1, 0};
    tbl[1]  = '{0,   0, 0, 0, 0, 0,   1, 1,   64, 0, 0};
    tbl[2]  = '{0,   0, 0, 0, 0, 0,   1, 0,   64, 0, 0};
    tbl[3]  = '{0,   0, 1, 0, 0, 0,   2, 0,   64, 0, 0};
    tbl[4]  = '{0,   0, 0, 0, 0, 0,   2, 0,   64, 0, 0};
    tbl[5]  = '{0,   0, 0, 1, 0, 0,   3, 0,   64, 0, 0};
    tbl[6]  = '{0,   0, 0, 0, 0, 0,   0, 0,   64, 0, 1};
    tbl[7]  = '{1,   0, 0, 0, 0, 0,   0, 0,   64, 1, 1};
    tbl[8]  = '{1,   8, 0, 0, 0, 0,   0, 0,   64, 1, 1};
    tbl[9]  = '{0,   0, 0, 0, 0, 0,   1, 1,    8, 0, 1};
    tbl[10] = '{0,   0, 1, 1, 0, 0,   3, 0,    8, 0, 1};
    tbl[11] = '{0,   0, 0, 0, 0, 0,   0, 0,    8, 0, 2};
    tbl[12] = '{1, 100, 0, 0, 0, 0,   0, 0,    8, 1, 2};
    tbl[13] = '{1, 200, 0, 0, 0, 0,   1, 1,  100, 1, 2};
    tbl[14] = '{0,   0, 1, 0, 0, 0,   2, 0,  100, 1, 2};
    tbl[15] = '{0,   0, 0, 0, 1, 0,   0, 0,  100, 1, 2};
    tbl[16] = '{0,   0, 0, 0, 0, 0,   1, 1,  200, 0, 2};
    tbl[17] = '{0,   0, 1, 0, 1, 0,   0, 0,  200, 0, 2};
    tbl[18] = '{0,   0, 0, 1, 1, 0,   0, 0,  200, 0, 2};
    tbl[19] = '{1,   5, 0, 0, 0, 0,   0, 0,  200, 1, 2};
    tbl[20] = '{0,   0, 0, 0, 0, 0,   1, 1,    5, 0, 2};
    tbl[21] = '{0,   0, 0, 1, 0, 0,   1, 0,    5, 0, 2};
    tbl[22] = '{0,   0, 1, 0, 0, 0,   2, 0,    5, 0, 2};
    tbl[23] = '{0,   0, 0, 1, 0, 0,   3, 0,    5, 0, 2};
    tbl[24] = '{0,   0, 0, 0, 0, 0,   0, 0,    5, 0, 3};

    for (int i = 0; i < NV; i++) begin
      bus.req_valid   = tbl[i].v[0];
      bus.req_len     = 16'(tbl[i].len);
      bus.rd_ctrl_rdy = tbl[i].rd[0];
      bus.wr_ctrl_rdy = tbl[i].wr[0];
      bus.abort       = tbl[i].ab[0];
      bus.err_clr     = tbl[i].clr[0];
      step();
      tag = $sformatf("vec%0d", i);
      chk_status(tag, tbl[i].st, tbl[i].ql);
      chk({tag, "_rd_start"}, int'(bus.rd_start), tbl[i].start);
      chk({tag, "_wr_start"}, int'(bus.wr_start), tbl[i].start);
      chk({tag, "_xfer_len"}, int'(bus.xfer_len), tbl[i].xl);
      chk({tag, "_count"},    int'(bus.pkt_count), tbl[i].cnt);
    end
    bus.req_valid   = 1'b0;
    bus.rd_ctrl_rdy = 1'b0;
    bus.wr_ctrl_rdy = 1'b0;
    bus.abort       = 1'b0;
    bus.err_clr     = 1'b0;
    exp_cnt         = 3;

    // Fill the queue behind a stalled packet; the fifth request waits for space.
    bus.req_valid = 1'b1;
    bus.req_len   = 16'd1;
    step();
    wait_start(1);
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 1'b1;
      bus.req_len   = 16'(20 + k);
      step();
    end
    chk_status("q_full", 1, 4);
    bus.req_valid = 1'b1;
    bus.req_len   = 16'd24;
    step();
    step();
    chk_status("q_held", 1, 4);
    finish_pkt();
    for (int k = 0; k < 5; k++) begin
      wait_start(20 + k);
      finish_pkt();
    end
    chk_status("q_drained", 0, 0);

    // Watchdog expiry, dispatch while flagged, clear, then set racing a held clear.
    bus.req_valid = 1'b1;
    bus.req_len   = 16'd7;
    step();
    wait_start(7);
    run_to_timeout("tmo");
    bus.req_valid = 1'b1;
    bus.req_len   = 16'd3;
    step();
    wait_start(3);
    finish_pkt();
    chk("err_sticky", int'(bus.timeout_err), 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("err_cleared", int'(bus.timeout_err), 0);
    bus.err_clr   = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_len   = 16'd4;
    step();
    wait_start(4);
    run_to_timeout("tmo_clr");
    step();
    bus.err_clr = 1'b0;
    chk("err_clr_after_set", int'(bus.timeout_err), 0);

    // Reset while waiting for the write engine with two requests queued.
    bus.req_valid = 1'b1;
    bus.req_len   = 16'd9;
    step();
    wait_start(9);
    bus.req_valid = 1'b1;
    bus.req_len   = 16'd30;
    step();
    bus.req_valid = 1'b1;
    bus.req_len   = 16'd31;
    step();
    bus.rd_ctrl_rdy = 1'b1;
    step();
    bus.rd_ctrl_rdy = 1'b0;
    chk_status("pre_reset", 2, 2);
    reset = 1'b1;
    step();
    reset   = 1'b0;
    exp_cnt = 0;
    chk_status("post_reset", 0, 0);
    chk("post_reset_start", int'(bus.rd_start), 0);
    chk("post_reset_xfer_len", int'(bus.xfer_len), 0);
    chk("post_reset_count", int'(bus.pkt_count), exp_cnt);
    chk("post_reset_err", int'(bus.timeout_err), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_rd_start_after_reset", int'(bus.rd_start), 0);
      chk("no_wr_start_after_reset", int'(bus.wr_start), 0);
      chk("idle_after_reset", int'(bus.state_out), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
